uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an input FIFO, a programmable baud divider, configurable parity and 1 or 2 stop bits. It accepts words over a valid/ready handshake, buffers up to FIFO_DEPTH of them, and serialises frames back-to-back on TX_OUT with no idle gap. It supersedes the fixed 8-bit, one-clock-per-bit, single-word transmitter in the UART subsystem.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 4, input FIFO entries; power of 2, at least 2.
DIV_W, 16, width of baud_div.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
s_data  input  DATA_W  word to transmit.
s_valid  input  1  s_data is valid.
s_ready  output  1  FIFO can accept a word (FIFO not full).
par_en  input  1  1 = insert a parity bit after the data bits.
par_typ  input  1  0 = even parity, 1 = odd parity.
stop2  input  1  0 = one stop bit, 1 = two stop bits.
baud_div  input  DIV_W  bit period is baud_div+1 clk cycles.
TX_OUT  output  1  serial line, registered, idles high.
busy  output  1  a frame is in progress (state != IDLE).
fifo_count  output  $clog2(FIFO_DEPTH+1)  number of occupied FIFO entries.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. While rst=1 at a clk edge: FIFO emptied, fifo_count=0, s_ready=1, state=IDLE, TX_OUT=1, busy=0, baud counter=0. Reset mid-frame aborts the frame immediately; TX_OUT is 1 on the cycle after the reset edge.
- Push: a word is written when s_valid && s_ready at a clk edge. s_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
- Push and pop in the same cycle: count unchanged. Pop on an empty FIFO never occurs; push into an empty FIFO is visible to the FSM on the next cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if the FIFO is non-empty, pop the head into the shift register, latch par_en, par_typ, stop2 and baud_div for the whole frame, compute the parity bit (XOR of data, inverted when par_typ=1), and go to START. TX_OUT=0 from the next cycle, so latency from a push into an empty idle block to the start bit is 2 cycles.
- Bit timing: the baud counter counts 0..div_latched. Each bit holds for exactly div_latched+1 cycles. A bit ends when count == div_latched; the count then resets to 0.
- START: drive 0 for one bit period, then go to DATA.
- DATA: drive the data LSB first for DATA_W bit periods, using a bit index of $clog2(DATA_W) bits. After the last bit, go to PARITY if par_en, otherwise go to STOP.
- PARITY: drive the parity bit for one bit period, then go to STOP.
- STOP: drive 1 for 1 bit period, or 2 bit periods if stop2. At the end of STOP, if the FIFO is non-empty, pop and load as in IDLE and go directly to START, so the next start bit immediately follows the stop bit. Otherwise go to IDLE.
- Frame length in bits = 1 + DATA_W + par_en + 1 + stop2.
- Configuration changes during a frame have no effect until the next frame load.
- busy=1 from the cycle the start bit appears until the cycle after the last stop bit ends with an empty FIFO.

Test Plan:
1. Reset, then baud_div=3, par_en=0, stop2=0, push 0xA5 -> TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; start bit 2 cycles after push; busy high for 40 cycles; TX_OUT=1 afterwards.
2. baud_div=0, par_en=1, par_typ=0, push 0xA5 -> 11-bit frame ending with parity 0 then stop 1. Repeat with par_typ=1 -> parity bit 1. Repeat with data 0x07 and even parity -> parity bit 1.
3. stop2=1, baud_div=1, push 0x00 and 0xFF on consecutive cycles -> two frames of 11 bits each (22 cycles per frame). The second start bit follows the second stop bit with no idle cycle; busy stays high throughout.
4. FIFO_DEPTH=4, baud_div=7, hold s_valid=1 with data 1..6 -> s_ready drops once fifo_count reaches 4, then reasserts after each pop. All 6 words are transmitted in order 1..6 with none lost or duplicated.
5. Assert rst for 1 cycle during the 3rd data bit of a frame, with 2 words queued -> TX_OUT=1, busy=0, fifo_count=0, s_ready=1 on the next cycle, and no further frames are sent.
6. Change baud_div from 3 to 1 mid-frame -> the current frame keeps 4-cycle bits; the next queued frame uses 2-cycle bits.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with input FIFO, baud divider, parity and 1/2 stop bits
// Frames are loaded from the FIFO with their configuration latched, and chained back-to-back.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_W-1:0]                    s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic                                 par_en,
  input  logic                                 par_typ,
  input  logic                                 stop2,
  input  logic [DIV_W-1:0]                     baud_div,
  output logic                                 TX_OUT,
  output logic                                 busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push, pop, fifo_empty;
  logic [DATA_W-1:0] head;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              par_bit_q, par_bit_d;
  logic              par_en_q, par_en_d;
  logic              stop2_q, stop2_d;
  logic              second_stop_q, second_stop_d;
  logic              tx_q, tx_d;
  logic              bit_end, load;

  assign s_ready    = (count_q != FULL_CNT);
  assign push       = s_valid && s_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign TX_OUT     = tx_q;
  assign bit_end    = (baud_cnt_q == div_q);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      baud_cnt_q    <= '0;
      div_q         <= '0;
      shift_q       <= '0;
      bit_idx_q     <= '0;
      par_bit_q     <= 1'b0;
      par_en_q      <= 1'b0;
      stop2_q       <= 1'b0;
      second_stop_q <= 1'b0;
      tx_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      baud_cnt_q    <= baud_cnt_d;
      div_q         <= div_d;
      shift_q       <= shift_d;
      bit_idx_q     <= bit_idx_d;
      par_bit_q     <= par_bit_d;
      par_en_q      <= par_en_d;
      stop2_q       <= stop2_d;
      second_stop_q <= second_stop_d;
      tx_q          <= tx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    baud_cnt_d    = baud_cnt_q;
    div_d         = div_q;
    shift_d       = shift_q;
    bit_idx_d     = bit_idx_q;
    par_bit_d     = par_bit_q;
    par_en_d      = par_en_q;
    stop2_d       = stop2_q;
    second_stop_d = second_stop_q;
    load          = 1'b0;
    pop           = 1'b0;

    if (state_q != S_IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d       = par_en_q ? S_PARITY : S_STOP;
            second_stop_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d       = S_STOP;
          second_stop_d = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && !second_stop_q) second_stop_d = 1'b1;
          else if (!fifo_empty)          load = 1'b1;
          else                           state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loading latches the whole frame configuration so later input changes cannot disturb it.
    if (load) begin
      pop           = 1'b1;
      state_d       = S_START;
      baud_cnt_d    = '0;
      div_d         = baud_div;
      shift_d       = head;
      par_bit_d     = (^head) ^ par_typ;
      par_en_d      = par_en;
      stop2_d       = stop2;
      second_stop_d = 1'b0;
    end
  end

  // The line is registered from next-state values so it changes on the same edge as the state.
  always_comb begin
    busy = (state_q != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule
